// File: rtl/kronos_hazard_ctrl.sv
// Register scoreboard and ID->EX issue gate for the two-cycle EX stage.
// Tracks in-flight writes per register, stalls on RAW/WAW-saturation, selects WB forwarding.
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   id_vld / id_rdy            ID->EX handshake (id_rdy = issue)
//   id_rs1/2, id_rs1/2_read    source operands of the ID instruction
//   id_rd, id_rd_write         destination of the ID instruction
//   ex_in_vld / ex_in_rdy      valid to EX, EX ready
//   wb_vld, wb_rd, wb_rd_write retiring instruction
//   fwd_rs1, fwd_rs2           take operand from WB write data
//   flush                      drop all tracking
//   stall, busy, err_underflow status
module kronos_hazard_ctrl #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_vld,
  output logic       id_rdy,
  input  logic [4:0] id_rs1,
  input  logic       id_rs1_read,
  input  logic [4:0] id_rs2,
  input  logic       id_rs2_read,
  input  logic [4:0] id_rd,
  input  logic       id_rd_write,
  output logic       ex_in_vld,
  input  logic       ex_in_rdy,
  input  logic       wb_vld,
  input  logic [4:0] wb_rd,
  input  logic       wb_rd_write,
  output logic       fwd_rs1,
  output logic       fwd_rs2,
  input  logic       flush,
  output logic       stall,
  output logic       busy,
  output logic       err_underflow
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic             err_q, err_d;

  logic ret, pend1, pend2, haz1, haz2, sat, issue;

  always_comb begin
    ret   = wb_vld & wb_rd_write & (wb_rd != 5'd0);
    pend1 = id_rs1_read & (id_rs1 != 5'd0)
          & (cnt_q[id_rs1] != '0);
    pend2 = id_rs2_read & (id_rs2 != 5'd0)
          & (cnt_q[id_rs2] != '0);
    // Last outstanding write retires now: bypass instead of stalling.
    fwd_rs1 = pend1 & ret & (wb_rd == id_rs1)
            & (cnt_q[id_rs1] == ONE);
    fwd_rs2 = pend2 & ret & (wb_rd == id_rs2)
            & (cnt_q[id_rs2] == ONE);
    haz1 = pend1 & ~fwd_rs1;
    haz2 = pend2 & ~fwd_rs2;
    // A full counter can still take a writer if one retires this cycle.
    sat = id_rd_write & (id_rd != 5'd0)
        & (cnt_q[id_rd] == MAX)
        & ~(ret & (wb_rd == id_rd));
    stall     = id_vld & (haz1 | haz2 | sat | flush);
    ex_in_vld = id_vld & ~stall;
    issue     = ex_in_vld & ex_in_rdy;
    id_rdy    = issue;
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 1; r < 32; r++)
      busy = busy | (cnt_q[r] != '0);
  end

  always_comb begin
    logic inc, dec;
    cnt_d = cnt_q;
    err_d = err_q;
    inc   = 1'b0;
    dec   = 1'b0;
    cnt_d[0] = '0;
    for (int r = 1; r < 32; r++) begin
      inc = issue & id_rd_write & (id_rd == 5'(r));
      dec = ret & (wb_rd == 5'(r));
      if (flush)
        cnt_d[r] = '0;
      else if (dec && cnt_q[r] == '0)
        err_d = 1'b1;
      else if (inc && !dec)
        cnt_d[r] = cnt_q[r] + ONE;
      else if (dec && !inc)
        cnt_d[r] = cnt_q[r] - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++)
        cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++)
        cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
    end
  end

  assign err_underflow = err_q;

endmodule
